leaf_stage_buffer: RTL and testbench

//  Leaf stage under each rootModule400_*_sa9_<n> branch node. Consumes the word stream

---
 rtl/leaf_stage_pkg.sv | 13 +
 rtl/leaf_stage_buffer_if.sv | 50 +++++
 rtl/leaf_stage_ram.sv | 25 ++
 rtl/leaf_stage_buffer.sv | 115 +++++++++++
 tb/tb_leaf_stage_buffer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leaf_stage_pkg.sv
// Shared types and widths for the leaf stage buffer (checksum option: LEAF_STAGE_CHECKSUM_EN).
package leaf_stage_pkg;

  localparam int ID_W  = 3;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/leaf_stage_buffer_if.sv
// Word-stream handshake bundle between a parent branch, a leaf buffer and its consumer.
// The checksum signal exists only when LEAF_STAGE_CHECKSUM_EN is defined.
interface leaf_stage_buffer_if #(
  parameter int DATA_W = 8
);
  import leaf_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ID_W-1:0]   out_id;
  logic [CNT_W-1:0]  word_cnt;
`ifdef LEAF_STAGE_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  // Leaf side: accepts words on in_*, presents them on out_*.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_id,
`ifdef LEAF_STAGE_CHECKSUM_EN
    output checksum,
`endif
    output word_cnt
  );

  // Environment side: produces upstream words and consumes downstream words.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_id,
`ifdef LEAF_STAGE_CHECKSUM_EN
    input  checksum,
`endif
    input  word_cnt
  );

endinterface

// File: rtl/leaf_stage_ram.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, contents never reset.
module leaf_stage_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/leaf_stage_buffer.sv
// Leaf FIFO stage: buffers the parent's word stream, tags it with INST_ID, counts pops.
// Optional XOR checksum of popped words under LEAF_STAGE_CHECKSUM_EN.
module leaf_stage_buffer
  import leaf_stage_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int INST_ID = 0
) (
  input  logic                clk,
  input  logic                rst,
  leaf_stage_buffer_if.slave  bus
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int OCC_W    = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_LAST = OCC_W'(DEPTH - 1);

  occ_state_t        r_state;
  occ_state_t        w_state_nxt;
  logic [OCC_W-1:0]  r_count;
  logic [OCC_W-1:0]  w_count_nxt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_push;
  logic              w_pop;

  // Handshake flags come from registered state only, so in_ready never sees out_ready.
  assign w_in_ready  = (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
      case (r_state)
        EMPTY:   w_state_nxt = PARTIAL;
        PARTIAL: if (r_count == OCC_LAST) w_state_nxt = FULL;
        default: w_state_nxt = r_state;
      endcase
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
      case (r_state)
        FULL:    w_state_nxt = PARTIAL;
        PARTIAL: if (r_count == OCC_ONE) w_state_nxt = EMPTY;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  leaf_stage_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

`ifdef LEAF_STAGE_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum ^ w_rd_data;
    end
  end

  assign bus.checksum = r_checksum;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_rd_data;
  assign bus.out_id    = ID_W'(INST_ID);
  assign bus.word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_leaf_stage_buffer.sv
// Scoreboard bench for leaf_stage_buffer (DEPTH=4, INST_ID=2); checksum checks under LEAF_STAGE_CHECKSUM_EN.
module tb_leaf_stage_buffer;
  import leaf_stage_pkg::*;

  localparam int DW = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [DW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_wcnt;
  logic [DW-1:0]    exp_csum;

  leaf_stage_buffer_if #(.DATA_W(DW)) bus ();

  leaf_stage_buffer #(
    .DATA_W  (DW),
    .DEPTH   (4),
    .INST_ID (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle; report what the DUT did at the edge (sampled on the falling edge).
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       output logic pushed, output logic popped,
                       output logic [DW-1:0] pdata, output logic ovld);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(negedge clk);
    pushed = bus.in_valid & bus.in_ready;
    popped = bus.out_valid & bus.out_ready;
    pdata  = bus.out_data;
    ovld   = bus.out_valid;
    @(posedge clk);
    #1;
    if (pushed === 1'b1) exp_q.push_back(d);
    if (popped === 1'b1) begin
      exp_wcnt = exp_wcnt + 1'b1;
      exp_csum = exp_csum ^ pdata;
    end
  endtask

  task automatic test_reset;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_wcnt = '0;
    exp_csum = '0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_word_cnt got %0d want 0", bus.word_cnt);
    end
    checks++;
    if (bus.out_id !== 3'd2) begin
      errors++;
      $display("FAIL reset_out_id got %0d want 2", bus.out_id);
    end
`ifdef LEAF_STAGE_CHECKSUM_EN
    checks++;
    if (bus.checksum !== 8'h00) begin
      errors++;
      $display("FAIL reset_checksum got %h want 00", bus.checksum);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    logic pu, po, ov;
    logic [DW-1:0] pd, e;
    cycle(1'b1, 8'hA5, 1'b1, pu, po, pd, ov);
    checks++;
    if (pu !== 1'b1 || po !== 1'b0) begin
      errors++;
      $display("FAIL single_edge1 push=%b pop=%b want 1 0", pu, po);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_present valid=%b data=%h want 1 a5", bus.out_valid, bus.out_data);
    end
    cycle(1'b0, 8'h00, 1'b1, pu, po, pd, ov);
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (po !== 1'b1 || pd !== e) begin
      errors++;
      $display("FAIL single_pop pop=%b data=%h want 1 %h", po, pd, e);
    end
    checks++;
    if (bus.word_cnt !== exp_wcnt || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after word_cnt=%0d valid=%b want %0d 0", bus.word_cnt, bus.out_valid, exp_wcnt);
    end
`ifdef LEAF_STAGE_CHECKSUM_EN
    checks++;
    if (bus.checksum !== 8'hA5) begin
      errors++;
      $display("FAIL single_checksum got %h want a5", bus.checksum);
    end
`endif
  endtask

  task automatic test_fill;
    logic pu, po, ov;
    logic [DW-1:0] pd, e;
    logic [DW-1:0] csum_before;
    int npop;
    csum_before = exp_csum;
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0, pu, po, pd, ov);
    checks++;
    if (bus.in_ready !== 1'b0 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL fill_full in_ready=%b pushes=%0d want 0 4", bus.in_ready, exp_q.size());
    end
    cycle(1'b1, 8'h05, 1'b0, pu, po, pd, ov);
    checks++;
    if (pu !== 1'b0) begin
      errors++;
      $display("FAIL fill_fifth_push accepted=%b want 0", pu);
    end
    npop = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'h00, 1'b1, pu, po, pd, ov);
      if (po === 1'b1) begin
        npop++;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (pd !== e) begin
          errors++;
          $display("FAIL fill_drain got %h want %h", pd, e);
        end
      end
    end
    checks++;
    if (npop != 4 || bus.word_cnt !== exp_wcnt) begin
      errors++;
      $display("FAIL fill_count pops=%0d word_cnt=%0d want 4 %0d", npop, bus.word_cnt, exp_wcnt);
    end
`ifdef LEAF_STAGE_CHECKSUM_EN
    checks++;
    if ((bus.checksum ^ csum_before) !== 8'h04) begin
      errors++;
      $display("FAIL fill_checksum got %h want %h", bus.checksum, csum_before ^ 8'h04);
    end
`endif
  endtask

  task automatic test_full_pop;
    logic pu, po, ov;
    logic [DW-1:0] pd, e;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h20 + DW'(i), 1'b0, pu, po, pd, ov);
    cycle(1'b1, 8'h24, 1'b1, pu, po, pd, ov);
    checks++;
    e = 8'h20;
    if (pu !== 1'b0 || po !== 1'b1 || pd !== e) begin
      errors++;
      $display("FAIL fullpop_edge push=%b pop=%b data=%h want 0 1 %h", pu, po, pd, e);
    end
    if (po === 1'b1 && exp_q.size() != 0) void'(exp_q.pop_front());
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_slot in_ready=%b want 1", bus.in_ready);
    end
    cycle(1'b1, 8'h24, 1'b0, pu, po, pd, ov);
    checks++;
    if (pu !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_refill push=%b in_ready=%b want 1 0", pu, bus.in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'h00, 1'b1, pu, po, pd, ov);
      if (po === 1'b1) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (pd !== e) begin
          errors++;
          $display("FAIL fullpop_drain got %h want %h", pd, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_empty left=%0d valid=%b want 0 0", exp_q.size(), bus.out_valid);
    end
  endtask

  task automatic test_wrap;
    logic pu, po, ov, ordy;
    logic [DW-1:0] pd, e;
    int nxt, npop, cyc;
    nxt = 0;
    npop = 0;
    cyc = 0;
    while ((nxt < 10 || exp_q.size() != 0) && cyc < 300) begin
      ordy = 1'($urandom_range(0, 1));
      cycle(nxt < 10, 8'h10 + DW'(nxt), ordy, pu, po, pd, ov);
      cyc++;
      if (pu === 1'b1) nxt++;
      if (po === 1'b1) begin
        npop++;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (pd !== e) begin
          errors++;
          $display("FAIL wrap_order got %h want %h", pd, e);
        end
      end else if (ov === 1'b1) begin
        checks++;
        if (bus.out_data !== pd) begin
          errors++;
          $display("FAIL wrap_stall_stable got %h want %h", bus.out_data, pd);
        end
      end
    end
    checks++;
    if (npop != 10 || cyc >= 300) begin
      errors++;
      $display("FAIL wrap_total pops=%0d cycles=%0d want 10 <300", npop, cyc);
    end
    checks++;
    if (bus.word_cnt !== exp_wcnt) begin
      errors++;
      $display("FAIL wrap_word_cnt got %0d want %0d", bus.word_cnt, exp_wcnt);
    end
  endtask

  task automatic test_reset_mid;
    logic pu, po, ov;
    logic [DW-1:0] pd, e;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + DW'(i), 1'b0, pu, po, pd, ov);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_wcnt = '0;
    exp_csum = '0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.word_cnt !== 16'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_flags valid=%b word_cnt=%0d in_ready=%b want 0 0 1",
               bus.out_valid, bus.word_cnt, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h7E, 1'b1, pu, po, pd, ov);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, pu, po, pd, ov);
      if (po === 1'b1) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (pd !== e || e !== 8'h7E) begin
          errors++;
          $display("FAIL midrst_first got %h want 7e", pd);
        end
      end
    end
    checks++;
    if (bus.word_cnt !== 16'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_after word_cnt=%0d left=%0d want 1 0", bus.word_cnt, exp_q.size());
    end
`ifdef LEAF_STAGE_CHECKSUM_EN
    checks++;
    if (bus.checksum !== 8'h7E) begin
      errors++;
      $display("FAIL midrst_checksum got %h want 7e", bus.checksum);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
